// File: rtl/uart_rx_controller_if.sv
// rtl/uart_rx_controller_if.sv - received-word handshake between the UART receiver and its consumer
interface uart_rx_controller_if #(
    parameter int DATA_BITS = 8
) ();
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_controller.sv
// rtl/uart_rx_controller.sv - oversampled UART receiver with one-word holding register and error pulses
module uart_rx_controller #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_tick,
    input  logic                        rx,
    uart_rx_controller_if.master        rx_if,
    output logic                        frame_error,
    output logic                        overrun,
    output logic                        busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] TICK_MID = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END = TW'(OVERSAMPLE - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic                 rx_meta_q, rx_s_q;
    logic [TW-1:0]        tick_q, tick_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 ovr_q, ovr_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;

        // A consumed word drops valid unless the stop-bit path below reloads it.
        if (valid_q && rx_if.rx_ready) begin
            valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (!rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
            end
            START: begin
                if (s_tick) begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s_q) begin
                            state_d = DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = STOP;
                            bit_d   = '0;
                        end else begin
                            bit_d = bit_q + 3'd1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (tick_q == TICK_END) begin
                        state_d = IDLE;
                        tick_d  = '0;
                        if (!rx_s_q) begin
                            ferr_d = 1'b1;
                        end else if (!valid_q || rx_if.rx_ready) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            ovr_d = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.rx_data  = data_q;
    assign rx_if.rx_valid = valid_q;
    assign frame_error    = ferr_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_controller.sv
// tb/tb_uart_rx_controller.sv - scenario bench for uart_rx_controller with an expected-word scoreboard
module tb_uart_rx_controller;

    localparam int OS  = 16;
    localparam int DB  = 8;
    // Two synchronizer cycles from the driven line to rx_s, then the frame-to-valid latency.
    localparam int LAT = 2 + OS / 2 + OS * (DB + 1) + 1;

    logic clk;
    logic reset_n;
    logic s_tick;
    logic rx;
    logic frame_error;
    logic overrun;
    logic busy;

    uart_rx_controller_if #(.DATA_BITS(DB)) rx_if ();

    uart_rx_controller #(
        .DATA_BITS  (DB),
        .OVERSAMPLE (OS)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .s_tick      (s_tick),
        .rx          (rx),
        .rx_if       (rx_if),
        .frame_error (frame_error),
        .overrun     (overrun),
        .busy        (busy)
    );

    int checks   = 0;
    int failures = 0;
    int tick_div = 4;
    int tick_phase = 0;

    logic [7:0] exp_q[$];
    logic [7:0] got_q[$];
    logic [7:0] exp_w, got_w;
    int   valid_cycles, fe_cnt, fe_long, ov_cnt, ov_long;
    logic fe_prev = 1'b0;
    logic ov_prev = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            tick_phase = tick_phase + 1;
            if (tick_phase >= tick_div) tick_phase = 0;
            s_tick = (tick_phase == 0);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rx_if.rx_valid) begin
                valid_cycles++;
                if (rx_if.rx_ready) got_q.push_back(rx_if.rx_data);
            end
            if (frame_error) begin
                fe_cnt++;
                if (fe_prev) fe_long++;
            end
            if (overrun) begin
                ov_cnt++;
                if (ov_prev) ov_long++;
            end
            fe_prev = frame_error;
            ov_prev = overrun;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout exp finish");
        $fatal(1, "watchdog");
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic clear_counts();
        valid_cycles = 0;
        fe_cnt = 0; fe_long = 0;
        ov_cnt = 0; ov_long = 0;
        got_q.delete();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_ok, input int idle_bits);
        int bc;
        bc = OS * tick_div;
        rx = 1'b0;
        wait_cyc(bc);
        for (int i = 0; i < DB; i++) begin
            rx = d[i];
            wait_cyc(bc);
        end
        if (stop_ok) begin
            rx = 1'b1;
            wait_cyc(bc);
        end else begin
            // Bad stop bit released early so the tail is not mistaken for a new start bit.
            rx = 1'b0;
            wait_cyc(bc * 3 / 4);
            rx = 1'b1;
            wait_cyc(bc / 4);
        end
        rx = 1'b1;
        wait_cyc(bc * idle_bits);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        rx = 1'b1;
        rx_if.rx_ready = 1'b0;
        wait_cyc(4);
        checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL reset_rx_data got=%0h exp=00", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL reset_rx_valid got=%0b exp=0", rx_if.rx_valid); end
        checks++; if (frame_error !== 1'b0) begin failures++; $display("FAIL reset_frame_error got=%0b exp=0", frame_error); end
        checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun got=%0b exp=0", overrun); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        reset_n = 1'b1;
        wait_cyc(4);
    endtask

    task automatic test_single_word();
        clear_counts();
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 2);
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL single_accept_count got=%0d exp=1", got_q.size());
        end else begin
            got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL single_data got=%0h exp=%0h", got_w, exp_w); end
        end
        checks++; if (valid_cycles !== 1) begin failures++; $display("FAIL single_valid_cycles got=%0d exp=1", valid_cycles); end
        checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL single_frame_error got=%0d exp=0", fe_cnt); end
        checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL single_overrun got=%0d exp=0", ov_cnt); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_after got=%0b exp=0", busy); end
    endtask

    task automatic test_glitch();
        clear_counts();
        rx_if.rx_ready = 1'b0;
        rx = 1'b0;
        wait_cyc(3 * tick_div);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL glitch_busy_during got=%0b exp=1", busy); end
        rx = 1'b1;
        wait_cyc(20 * tick_div);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL glitch_busy_after got=%0b exp=0", busy); end
        checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL glitch_valid got=%0d exp=0", valid_cycles); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin failures++; $display("FAIL glitch_pulses got=%0d exp=0", fe_cnt + ov_cnt); end
    endtask

    task automatic test_frame_error();
        reset_n = 1'b0;
        wait_cyc(2);
        reset_n = 1'b1;
        wait_cyc(2);
        clear_counts();
        rx_if.rx_ready = 1'b0;
        send_frame(8'h3C, 1'b0, 2);
        checks++; if (fe_cnt !== 1) begin failures++; $display("FAIL ferr_count got=%0d exp=1", fe_cnt); end
        checks++; if (fe_long !== 0) begin failures++; $display("FAIL ferr_width got=%0d exp=0", fe_long); end
        checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL ferr_overrun got=%0d exp=0", ov_cnt); end
        checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL ferr_valid got=%0d exp=0", valid_cycles); end
        checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL ferr_rx_data got=%0h exp=00", rx_if.rx_data); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL ferr_busy got=%0b exp=0", busy); end
    endtask

    task automatic test_back_to_back_overrun();
        clear_counts();
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 0);
        checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL b2b_early_overrun got=%0d exp=0", ov_cnt); end
        send_frame(8'h22, 1'b1, 2);
        checks++; if (ov_cnt !== 1) begin failures++; $display("FAIL b2b_overrun_count got=%0d exp=1", ov_cnt); end
        checks++; if (ov_long !== 0) begin failures++; $display("FAIL b2b_overrun_width got=%0d exp=0", ov_long); end
        checks++; if (fe_cnt !== 0) begin failures++; $display("FAIL b2b_frame_error got=%0d exp=0", fe_cnt); end
        checks++; if (rx_if.rx_data !== 8'h11) begin failures++; $display("FAIL b2b_held_data got=%0h exp=11", rx_if.rx_data); end
        checks++; if (rx_if.rx_valid !== 1'b1) begin failures++; $display("FAIL b2b_held_valid got=%0b exp=1", rx_if.rx_valid); end
        rx_if.rx_ready = 1'b1;
        wait_cyc(1);
        rx_if.rx_ready = 1'b0;
        checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL b2b_valid_cleared got=%0b exp=0", rx_if.rx_valid); end
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL b2b_accept_count got=%0d exp=1", got_q.size());
        end else begin
            got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL b2b_data got=%0h exp=%0h", got_w, exp_w); end
        end
    endtask

    task automatic test_latency();
        int  n;
        logic seen;
        tick_div = 1;
        wait_cyc(4);
        clear_counts();
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(8'hC3);
        n = 0;
        seen = 1'b0;
        fork
            send_frame(8'hC3, 1'b1, 2);
            begin
                while (n < 400 && !seen) begin
                    wait_cyc(1);
                    n++;
                    if (rx_if.rx_valid) seen = 1'b1;
                end
            end
        join
        checks++; if (n !== LAT) begin failures++; $display("FAIL latency_cycles got=%0d exp=%0d", n, LAT); end
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL latency_accept_count got=%0d exp=1", got_q.size());
        end else begin
            got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL latency_data got=%0h exp=%0h", got_w, exp_w); end
        end
    endtask

    task automatic test_ready_at_stop();
        clear_counts();
        rx_if.rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1);
        checks++; if (rx_if.rx_data !== 8'h11) begin failures++; $display("FAIL same_pending_data got=%0h exp=11", rx_if.rx_data); end
        fork
            send_frame(8'h22, 1'b1, 2);
            begin
                // Cycle LAT-1 after the line drop is the stop-sample cycle.
                wait_cyc(LAT - 1);
                rx_if.rx_ready = 1'b1;
                wait_cyc(1);
                rx_if.rx_ready = 1'b0;
                checks++; if (rx_if.rx_data !== 8'h22) begin failures++; $display("FAIL same_reload_data got=%0h exp=22", rx_if.rx_data); end
                checks++; if (rx_if.rx_valid !== 1'b1) begin failures++; $display("FAIL same_reload_valid got=%0b exp=1", rx_if.rx_valid); end
            end
        join
        checks++; if (ov_cnt !== 0) begin failures++; $display("FAIL same_overrun got=%0d exp=0", ov_cnt); end
        checks++; if (rx_if.rx_data !== 8'h22) begin failures++; $display("FAIL same_data_stable got=%0h exp=22", rx_if.rx_data); end
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL same_accept_count got=%0d exp=1", got_q.size());
        end else begin
            got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL same_accept_data got=%0h exp=%0h", got_w, exp_w); end
        end
    endtask

    task automatic test_reset_mid_frame();
        tick_div = 4;
        wait_cyc(8);
        clear_counts();
        rx_if.rx_ready = 1'b0;
        fork
            send_frame(8'hFF, 1'b1, 2);
            begin
                wait_cyc(OS * 4 * 3);
                checks++; if (busy !== 1'b1) begin failures++; $display("FAIL midrst_busy_before got=%0b exp=1", busy); end
                reset_n = 1'b0;
                #1;
                checks++; if (rx_if.rx_data !== 8'h00) begin failures++; $display("FAIL midrst_rx_data got=%0h exp=00", rx_if.rx_data); end
                checks++; if (rx_if.rx_valid !== 1'b0) begin failures++; $display("FAIL midrst_rx_valid got=%0b exp=0", rx_if.rx_valid); end
                checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%0b exp=0", busy); end
                checks++; if ((frame_error | overrun) !== 1'b0) begin failures++; $display("FAIL midrst_pulses got=%0b exp=0", frame_error | overrun); end
                exp_q.delete();
                clear_counts();
                wait_cyc(3);
                reset_n = 1'b1;
            end
        join
        checks++; if (valid_cycles !== 0) begin failures++; $display("FAIL midrst_no_valid got=%0d exp=0", valid_cycles); end
        checks++; if (fe_cnt + ov_cnt !== 0) begin failures++; $display("FAIL midrst_no_pulse got=%0d exp=0", fe_cnt + ov_cnt); end
        rx_if.rx_ready = 1'b1;
        exp_q.push_back(8'h5A);
        send_frame(8'h5A, 1'b1, 2);
        checks++;
        if (got_q.size() !== 1) begin
            failures++; $display("FAIL midrst_next_count got=%0d exp=1", got_q.size());
        end else begin
            got_w = got_q.pop_front(); exp_w = exp_q.pop_front();
            checks++; if (got_w !== exp_w) begin failures++; $display("FAIL midrst_next_data got=%0h exp=%0h", got_w, exp_w); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rx = 1'b1;
        rx_if.rx_ready = 1'b0;
        test_reset();
        test_single_word();
        test_glitch();
        test_frame_error();
        test_back_to_back_overrun();
        test_latency();
        test_ready_at_stop();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
